// File: rtl/int_exec_pipe.sv
// int_exec_pipe: single-issue integer ALU feeding a DEPTH-stage elastic result pipeline onto the CDB.
// Optional macro INT_EXEC_FLUSH_EN adds an i_flush port that discards every in-flight result.
module int_exec_pipe #(
    parameter int BW_DATA   = 32,
    parameter int BW_OPCODE = 4,
    parameter int BW_TAG    = 4,
    parameter int DEPTH     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef INT_EXEC_FLUSH_EN
    input  logic                       i_flush,
`endif
    input  logic                       i_rsv_valid,
    output logic                       i_rsv_ready,
    input  logic [BW_OPCODE-1:0]       i_rsv_opcode,
    input  logic [BW_TAG-1:0]          i_rsv_tag,
    input  logic [2*BW_DATA-1:0]       i_rsv_V_flatten,
    output logic                       o_cdb_valid,
    input  logic                       o_cdb_ready,
    output logic [BW_TAG-1:0]          o_cdb_tag,
    output logic [BW_DATA-1:0]         o_cdb_wdata,
    output logic [$clog2(DEPTH+1)-1:0] o_inflight
);
    localparam int SHW = $clog2(BW_DATA);
    localparam int IW  = $clog2(DEPTH+1);

    function automatic logic [BW_DATA-1:0] alu_f(
        input logic [BW_OPCODE-1:0] op,
        input logic [BW_DATA-1:0]   a,
        input logic [BW_DATA-1:0]   b
    );
        logic [SHW-1:0]     sh;
        logic [BW_DATA-1:0] r;
        sh = b[SHW-1:0];
        case (op)
            BW_OPCODE'(0):  r = a + b;
            BW_OPCODE'(1):  r = a - b;
            BW_OPCODE'(2):  r = {{(BW_DATA-1){1'b0}}, ($signed(a) < $signed(b))};
            BW_OPCODE'(3):  r = {{(BW_DATA-1){1'b0}}, (a < b)};
            BW_OPCODE'(4):  r = a ^ b;
            BW_OPCODE'(5):  r = a | b;
            BW_OPCODE'(6):  r = a & b;
            BW_OPCODE'(7):  r = a << sh;
            BW_OPCODE'(8):  r = a >> sh;
            BW_OPCODE'(9):  r = $unsigned($signed(a) >>> sh);
            BW_OPCODE'(10): r = b;
            default:        r = a + b;
        endcase
        return r;
    endfunction

    logic               flush_s;
    logic               accept_s;
    logic               retire_s;
    logic [DEPTH-1:0]   load_s;
    logic [BW_DATA-1:0] result_s;
    logic [DEPTH-1:0]   valid_r;
    logic [BW_TAG-1:0]  tag_r  [DEPTH];
    logic [BW_DATA-1:0] data_r [DEPTH];
    logic [IW-1:0]      inflight_r;

`ifdef INT_EXEC_FLUSH_EN
    assign flush_s = i_flush;
`else
    assign flush_s = 1'b0;
`endif

    // Backpressure chain: a stage may load when empty or when its successor drains it.
    always_comb begin
        load_s          = '0;
        load_s[DEPTH-1] = ~valid_r[DEPTH-1] | o_cdb_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            load_s[k] = ~valid_r[k] | load_s[k+1];
        end
    end

    assign result_s    = alu_f(i_rsv_opcode, i_rsv_V_flatten[BW_DATA-1:0],
                               i_rsv_V_flatten[2*BW_DATA-1:BW_DATA]);
    assign i_rsv_ready = load_s[0] & ~flush_s;
    assign accept_s    = i_rsv_valid & i_rsv_ready;
    assign o_cdb_valid = valid_r[DEPTH-1] & ~flush_s;
    assign retire_s    = o_cdb_valid & o_cdb_ready;
    assign o_cdb_tag   = tag_r[DEPTH-1];
    assign o_cdb_wdata = data_r[DEPTH-1];
    assign o_inflight  = inflight_r;

    // Stage registers and occupancy counter; a full stage only moves when the next one takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r    <= '0;
            inflight_r <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                tag_r[k]  <= '0;
                data_r[k] <= '0;
            end
        end else if (flush_s) begin
            valid_r    <= '0;
            inflight_r <= '0;
        end else begin
            if (load_s[0]) begin
                valid_r[0] <= accept_s;
                tag_r[0]   <= i_rsv_tag;
                data_r[0]  <= result_s;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (load_s[k]) begin
                    valid_r[k] <= valid_r[k-1];
                    tag_r[k]   <= tag_r[k-1];
                    data_r[k]  <= data_r[k-1];
                end
            end
            case ({accept_s, retire_s})
                2'b10:   inflight_r <= inflight_r + IW'(1);
                2'b01:   inflight_r <= inflight_r - IW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end
endmodule

// File: tb/tb_int_exec_pipe.sv
// Self-checking bench for int_exec_pipe (DEPTH=3): directed ALU vectors, streaming, backpressure,
// random traffic, asynchronous reset and (with INT_EXEC_FLUSH_EN) flush, scored against a result queue.
module tb_int_exec_pipe;
    localparam int BW_DATA   = 32;
    localparam int BW_OPCODE = 4;
    localparam int BW_TAG    = 4;
    localparam int DEPTH     = 3;
    localparam int IW        = $clog2(DEPTH+1);

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
        int          cyc;
    } sb_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_rsv_valid = 1'b0;
    logic              i_rsv_ready;
    logic [3:0]        i_rsv_opcode = 4'd0;
    logic [3:0]        i_rsv_tag = 4'd0;
    logic [63:0]       i_rsv_V_flatten = 64'd0;
    logic              o_cdb_valid;
    logic              o_cdb_ready = 1'b1;
    logic [3:0]        o_cdb_tag;
    logic [31:0]       o_cdb_wdata;
    logic [IW-1:0]     o_inflight;
`ifdef INT_EXEC_FLUSH_EN
    logic              i_flush = 1'b0;
`endif

    int          n_asserts = 0;
    int          n_fail = 0;
    int          cnt = 0;
    int          cyc = 0;
    bit          acc, out;
    bit          chk_lat = 1'b1;
    bit          flushing = 1'b0;
    logic [31:0] pend_exp = 32'd0;
    sb_t         q[$];

    logic [3:0]  t_op [16] = '{4'd9, 4'd8, 4'd2, 4'd3, 4'd7, 4'd1, 4'd4, 4'd5,
                               4'd6, 4'd10, 4'd13, 4'd2, 4'd3, 4'd9, 4'd7, 4'd8};
    logic [31:0] t_v0 [16] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                               32'h80000000, 32'd10, 32'hF0F0F0F0, 32'hF0F0F0F0,
                               32'hF0F0F0F0, 32'h00001234, 32'd7, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'h7FFFFFF0, 32'd1, 32'h80000000};
    logic [31:0] t_v1 [16] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd33, 32'd3, 32'hFF00FF00,
                               32'hFF00FF00, 32'hFF00FF00, 32'hABCD5678, 32'hFFFFFFFF,
                               32'd1, 32'd1, 32'd4, 32'd31, 32'd63};
    logic [31:0] t_ex [16] = '{32'hC0000000, 32'h40000000, 32'd1, 32'd0, 32'd0, 32'd7,
                               32'h0FF00FF0, 32'hFFF0FFF0, 32'hF000F000, 32'hABCD5678,
                               32'd6, 32'd1, 32'd0, 32'h07FFFFFF, 32'h80000000, 32'd1};

    int_exec_pipe #(
        .BW_DATA(BW_DATA), .BW_OPCODE(BW_OPCODE), .BW_TAG(BW_TAG), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef INT_EXEC_FLUSH_EN
        .i_flush(i_flush),
`endif
        .i_rsv_valid(i_rsv_valid),
        .i_rsv_ready(i_rsv_ready),
        .i_rsv_opcode(i_rsv_opcode),
        .i_rsv_tag(i_rsv_tag),
        .i_rsv_V_flatten(i_rsv_V_flatten),
        .o_cdb_valid(o_cdb_valid),
        .o_cdb_ready(o_cdb_ready),
        .o_cdb_tag(o_cdb_tag),
        .o_cdb_wdata(o_cdb_wdata),
        .o_inflight(o_inflight)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned sh;
        logic [31:0] r;
        sh = 32'(b[4:0]);
        case (op)
            4'd1:    r = a - b;
            4'd2:    r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            4'd3:    r = {31'd0, a < b};
            4'd4:    r = a ^ b;
            4'd5:    r = a | b;
            4'd6:    r = a & b;
            4'd7:    r = a << sh;
            4'd8:    r = a >> sh;
            4'd9:    r = (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
            4'd10:   r = b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] tag, input logic [31:0] v0,
                        input logic [31:0] v1, input logic [31:0] exp);
        i_rsv_valid     = 1'b1;
        i_rsv_opcode    = op;
        i_rsv_tag       = tag;
        i_rsv_V_flatten = {v1, v0};
        pend_exp        = exp;
    endtask

    task automatic idle();
        i_rsv_valid = 1'b0;
    endtask

    task automatic sample();
        sb_t e;
        @(negedge clk);
        cyc++;
        acc = i_rsv_valid && i_rsv_ready;
        out = o_cdb_valid && o_cdb_ready;
        chk("inflight", 64'(o_inflight), 64'(cnt));
        if (q.size() == 0) begin
            chk("spurious_out", 64'(out), 64'd0);
        end else if (out) begin
            e = q.pop_front();
            chk("cdb_tag", 64'(o_cdb_tag), 64'(e.tag));
            chk("cdb_wdata", 64'(o_cdb_wdata), 64'(e.data));
            if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'(DEPTH));
        end
        if (acc) q.push_back('{i_rsv_tag, pend_exp, cyc});
        cnt = cnt + (acc ? 1 : 0) - (out ? 1 : 0);
        if (flushing) begin
            q.delete();
            cnt = 0;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        adv();
    endtask

    task automatic drain();
        idle();
        o_cdb_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0) break;
            cycle();
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int          bp_acc;
        bit          have_sv;
        logic [3:0]  sv_tag;
        logic [31:0] sv_data, v0, v1;
        logic [3:0]  op;

        // Reset state
        #2;
        chk("rst_valid", 64'(o_cdb_valid), 64'd0);
        chk("rst_tag", 64'(o_cdb_tag), 64'd0);
        chk("rst_wdata", 64'(o_cdb_wdata), 64'd0);
        chk("rst_inflight", 64'(o_inflight), 64'd0);
        chk("rst_ready", 64'(i_rsv_ready), 64'd1);
        adv();
        rst_n = 1'b1;
        chk("ready_after_rst", 64'(i_rsv_ready), 64'd1);

        // ADD 5 + (-7) with tag 3
        send(4'd0, 4'd3, 32'd5, 32'hFFFFFFF9, 32'hFFFFFFFE);
        cycle();
        drain();

        // Directed ALU vectors streamed back to back
        for (int i = 0; i < 16; i++) begin
            send(t_op[i], 4'(i), t_v0[i], t_v1[i], t_ex[i]);
            sample();
            chk("stream_ready", 64'(i_rsv_ready), 64'd1);
            if (i >= DEPTH) begin
                chk("stream_full", 64'(o_inflight), 64'(DEPTH));
                chk("stream_valid", 64'(o_cdb_valid), 64'd1);
            end
            adv();
        end
        drain();

        // Backpressure: sink stalled while requests are offered every cycle
        o_cdb_ready = 1'b0;
        bp_acc = 0;
        have_sv = 1'b0;
        sv_tag = 4'd0;
        sv_data = 32'd0;
        chk_lat = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(4'd0, 4'(i + 5), 32'(i), 32'd100, 32'(i + 100));
            sample();
            if (acc) bp_acc++;
            if (i >= DEPTH) begin
                chk("bp_ready_low", 64'(i_rsv_ready), 64'd0);
                chk("bp_valid_held", 64'(o_cdb_valid), 64'd1);
                if (!have_sv) begin
                    have_sv = 1'b1;
                    sv_tag  = o_cdb_tag;
                    sv_data = o_cdb_wdata;
                end else begin
                    chk("bp_tag_stable", 64'(o_cdb_tag), 64'(sv_tag));
                    chk("bp_data_stable", 64'(o_cdb_wdata), 64'(sv_data));
                end
            end
            adv();
        end
        chk("bp_accepts", 64'(bp_acc), 64'(DEPTH));
        chk("bp_inflight", 64'(o_inflight), 64'(DEPTH));
        idle();
        o_cdb_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            sample();
            chk("bp_drain_valid", 64'(out), 64'd1);
            adv();
        end
        sample();
        chk("bp_drained", 64'(o_cdb_valid), 64'd0);
        adv();

        // Random traffic with random sink stalls
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(9) < 7) begin
                op = 4'($urandom_range(15));
                v0 = $urandom();
                v1 = $urandom();
                send(op, 4'($urandom_range(15)), v0, v1, model(op, v0, v1));
            end else begin
                idle();
            end
            o_cdb_ready = ($urandom_range(9) < 6);
            cycle();
        end
        drain();
        chk_lat = 1'b1;

        // Asynchronous reset with two operations in flight
        send(4'd0, 4'd1, 32'd1, 32'd1, 32'd2);
        cycle();
        send(4'd0, 4'd2, 32'd2, 32'd2, 32'd4);
        cycle();
        idle();
        chk("pre_rst_inflight", 64'(o_inflight), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(o_cdb_valid), 64'd0);
        chk("arst_tag", 64'(o_cdb_tag), 64'd0);
        chk("arst_wdata", 64'(o_cdb_wdata), 64'd0);
        chk("arst_inflight", 64'(o_inflight), 64'd0);
        chk("arst_ready", 64'(i_rsv_ready), 64'd1);
        q.delete();
        cnt = 0;
        adv();
        rst_n = 1'b1;
        chk("arst_ready_after", 64'(i_rsv_ready), 64'd1);
        for (int i = 0; i < 2 * DEPTH; i++) cycle();

`ifdef INT_EXEC_FLUSH_EN
        // Flush with two operations in flight and a request pending
        send(4'd0, 4'd7, 32'd7, 32'd7, 32'd14);
        cycle();
        send(4'd0, 4'd8, 32'd8, 32'd8, 32'd16);
        cycle();
        send(4'd0, 4'd9, 32'd9, 32'd9, 32'd18);
        i_flush  = 1'b1;
        flushing = 1'b1;
        sample();
        chk("flush_ready", 64'(i_rsv_ready), 64'd0);
        chk("flush_cdb_valid", 64'(o_cdb_valid), 64'd0);
        adv();
        i_flush  = 1'b0;
        flushing = 1'b0;
        idle();
        sample();
        chk("flush_inflight", 64'(o_inflight), 64'd0);
        adv();
        for (int i = 0; i < 2 * DEPTH; i++) cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/int_exec_pipe.md
INT_EXEC_PIPE -- requirements
Module: int_exec_pipe

Interface
REQ-001 SHALL have parameter BW_DATA, default 32: operand and result width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have parameter BW_OPCODE, default 4: opcode width.
REQ-003 SHALL have parameter BW_TAG, default 4: reservation-station tag width.
REQ-004 SHALL have parameter DEPTH, default 2: pipeline stages; legal values are 1 to 4.
REQ-005 SHALL have ports clk (in, 1: clock) and rst_n (in, 1: reset); one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port i_rsv_valid (in, 1): request valid.
REQ-007 SHALL have port i_rsv_ready (out, 1): request accepted when valid and ready are both high.
REQ-008 SHALL have port i_rsv_opcode (in, BW_OPCODE): operation code.
REQ-009 SHALL have port i_rsv_tag (in, BW_TAG): destination tag.
REQ-010 SHALL have port i_rsv_V_flatten (in, 2*BW_DATA): V0 in the low half, V1 in the high half.
REQ-011 SHALL have ports o_cdb_valid (out, 1) and o_cdb_ready (in, 1): CDB two-wire handshake.
REQ-012 SHALL have port o_cdb_tag (out, BW_TAG): tag of the result.
REQ-013 SHALL have port o_cdb_wdata (out, BW_DATA): the result.
REQ-014 SHALL have port o_inflight (out, clog2(DEPTH+1)): number of occupied stages.

Function
REQ-015 SHALL decode opcodes as follows:
- 0 ADD; 1 SUB.
- 2 SLT (signed); 3 SLTU (unsigned).
- 4 XOR; 5 OR; 6 AND.
- 7 SLL; 8 SRL; 9 SRA.
- 10 PASS: result = V1.
- Any other opcode: ADD.
REQ-016 SHALL take the shift amount as V1[clog2(BW_DATA)-1:0] and ignore the upper bits of V1.
REQ-017 SHALL compute the result combinationally at accept, then carry result and tag through DEPTH registered stages, each with its own valid bit.
REQ-018 SHALL advance stage k when it is empty or when stage k+1 advances; the last stage advances when o_cdb_valid and o_cdb_ready are both high.
REQ-019 SHALL drive i_rsv_ready high when stage 0 is empty or stage 0 advances in the same cycle, giving one accept per cycle when there is no backpressure.
REQ-020 SHALL assert o_cdb_valid exactly DEPTH cycles after an accept when there is no backpressure.
REQ-021 SHALL, while o_cdb_ready is low, hold o_cdb_tag and o_cdb_wdata stable and lose no result; o_cdb_valid SHALL NOT drop until the transfer completes.
REQ-022 SHALL, when the pipeline is full and the output completes in a cycle, accept a new request in that same cycle, so occupancy stays at DEPTH.
REQ-023 SHALL deliver results in accept order.
REQ-024 SHALL make o_inflight equal the count of valid stage bits; it increments on accept-only, decrements on output-only, and holds on accept plus output.

Reset
REQ-025 SHALL, on rst_n low at any time, asynchronously clear all stage valid bits, tags and data to 0. Consequences:
- o_cdb_valid = 0, o_cdb_tag = 0, o_cdb_wdata = 0, o_inflight = 0.
- Operations in flight when reset asserts are discarded.
REQ-026 SHALL drive i_rsv_ready = 1 throughout reset and on the first cycle after rst_n goes high.

Configuration
REQ-027 SHALL, when macro INT_EXEC_FLUSH_EN is defined, add port i_flush (in, 1). A cycle with i_flush high:
- clears every stage valid bit at the next edge and sets o_inflight to 0;
- blocks any accept in that cycle (i_rsv_ready = 0);
- drives o_cdb_valid low combinationally.
REQ-028 SHALL, without INT_EXEC_FLUSH_EN, have no i_flush port and flush only via reset.

Verification
REQ-029 DEPTH=2: accept ADD, V0=5, V1=-7, tag 3 -> o_cdb_valid two cycles later, wdata=0xFFFFFFFE, tag 3.
REQ-030 V0=0x80000000, V1=1: SRA -> 0xC0000000; SRL -> 0x40000000; SLT -> 1; SLTU -> 0; SLL with V1=33 -> 0x00000000 (shift of 1).
REQ-031 DEPTH=3, o_cdb_ready low for 10 cycles with valid requests every cycle -> exactly 3 accepts, i_rsv_ready=0 afterwards, o_inflight=3, output stable; release -> tags appear in order, one per cycle.
REQ-032 Full pipeline with o_cdb_ready=1 and continuous input -> one result per cycle, o_inflight constant at DEPTH, no bubbles.
REQ-033 rst_n low mid-stream with 2 ops in flight -> all outputs 0 asynchronously, o_inflight=0; after release no stale result appears.
REQ-034 With INT_EXEC_FLUSH_EN: i_flush pulsed while 2 ops are in flight and a request is valid -> that request is not accepted, o_inflight=0 next cycle, no CDB transfer for the flushed ops.
